// File: rtl/rf_wb_arbiter_if.sv
// Write-back port bundle: ALU/LSU result inputs, scoreboard issue/query, and the RF write port.
// The arbiter uses the slave modport; the producer side uses master.
interface rf_wb_arbiter_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          alu_valid;
    logic [4:0]    alu_wa;
    logic [31:0]   alu_wd;
    logic          lsu_valid;
    logic          lsu_ready;
    logic [4:0]    lsu_wa;
    logic [31:0]   lsu_wd;
    logic          issue_en;
    logic [4:0]    issue_wa;
    logic [4:0]    pend_ra_k;
    logic [4:0]    pend_ra_j;
    logic [4:0]    pend_ra_d;
    logic          pend_k;
    logic          pend_j;
    logic          pend_d;
    logic          rf_we;
    logic [4:0]    rf_wa;
    logic [31:0]   rf_wd;
    logic [CW-1:0] fifo_cnt;

    modport slave (
        input  alu_valid, alu_wa, alu_wd,
        input  lsu_valid, lsu_wa, lsu_wd,
        output lsu_ready,
        input  issue_en, issue_wa,
        input  pend_ra_k, pend_ra_j, pend_ra_d,
        output pend_k, pend_j, pend_d,
        output rf_we, rf_wa, rf_wd, fifo_cnt
    );

    modport master (
        output alu_valid, alu_wa, alu_wd,
        output lsu_valid, lsu_wa, lsu_wd,
        input  lsu_ready,
        output issue_en, issue_wa,
        output pend_ra_k, pend_ra_j, pend_ra_d,
        input  pend_k, pend_j, pend_d,
        input  rf_we, rf_wa, rf_wd, fifo_cnt
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Merges ALU results (priority, 1 cycle) and FIFO-buffered LSU results (>=2 cycles, 1 with RF_WB_BYPASS_EN) onto the RF write port.
// lsu_ready drops only when the FIFO is full; ALU never stalls. Tracks outstanding long-latency writes in a pending scoreboard.
module rf_wb_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    rf_wb_arbiter_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [4:0]    mem_wa [DEPTH];
    logic [31:0]   mem_wd [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] cnt;
    logic [31:0]   pending;
    logic [31:0]   pending_nxt;
    logic          rf_we_q;
    logic [4:0]    rf_wa_q;
    logic [31:0]   rf_wd_q;

    logic          push;
    logic          pop;
    logic          byp;
    logic          fifo_wr;
    logic          sel_vld;
    logic [4:0]    sel_wa;
    logic [31:0]   sel_wd;
    logic          clr_vld;
    logic [4:0]    clr_wa;

    assign bus.lsu_ready = (cnt != CW'(DEPTH)) & ~rst;
    assign push          = bus.lsu_valid & bus.lsu_ready;
    assign pop           = ~bus.alu_valid & (cnt != '0);
`ifdef RF_WB_BYPASS_EN
    // An empty FIFO with an idle ALU lets the LSU result skip storage entirely.
    assign byp           = ~bus.alu_valid & (cnt == '0) & push;
`else
    assign byp           = 1'b0;
`endif
    assign fifo_wr       = push & ~byp;

    always_comb begin
        sel_vld = 1'b0;
        sel_wa  = bus.alu_wa;
        sel_wd  = bus.alu_wd;
        if (bus.alu_valid) begin
            sel_vld = 1'b1;
        end else if (pop) begin
            sel_vld = 1'b1;
            sel_wa  = mem_wa[rd_ptr];
            sel_wd  = mem_wd[rd_ptr];
        end else if (byp) begin
            sel_vld = 1'b1;
            sel_wa  = bus.lsu_wa;
            sel_wd  = bus.lsu_wd;
        end
    end

    // Clear before set so a same-register issue in the retiring cycle keeps the bit.
    always_comb begin
        clr_vld     = pop | byp;
        clr_wa      = pop ? mem_wa[rd_ptr] : bus.lsu_wa;
        pending_nxt = pending;
        if (clr_vld)
            pending_nxt[clr_wa] = 1'b0;
        if (bus.issue_en && (bus.issue_wa != 5'd0))
            pending_nxt[bus.issue_wa] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            mem_wa[wr_ptr] <= bus.lsu_wa;
            mem_wd[wr_ptr] <= bus.lsu_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            cnt     <= '0;
            pending <= '0;
            rf_we_q <= 1'b0;
            rf_wa_q <= 5'd0;
            rf_wd_q <= 32'd0;
        end else begin
            if (fifo_wr)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (fifo_wr && !pop)
                cnt <= cnt + CW'(1);
            else if (!fifo_wr && pop)
                cnt <= cnt - CW'(1);
            pending <= pending_nxt;
            if (sel_vld) begin
                rf_we_q <= (sel_wa != 5'd0);
                rf_wa_q <= sel_wa;
                rf_wd_q <= sel_wd;
            end else begin
                rf_we_q <= 1'b0;
            end
        end
    end

    assign bus.rf_we    = rf_we_q;
    assign bus.rf_wa    = rf_wa_q;
    assign bus.rf_wd    = rf_wd_q;
    assign bus.fifo_cnt = cnt;
    assign bus.pend_k   = pending[bus.pend_ra_k];
    assign bus.pend_j   = pending[bus.pend_ra_j];
    assign bus.pend_d   = pending[bus.pend_ra_d];
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: queue-based reference model checked every cycle, plus directed literal checks.
module tb_rf_wb_arbiter;
    localparam int DEPTH = 4;
`ifdef RF_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [4:0]  wa;
        logic [31:0] wd;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rf_wb_arbiter_if #(.DEPTH(DEPTH)) ifc ();
    rf_wb_arbiter #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(ifc));

    int checks   = 0;
    int failures = 0;

    ent_t          mq[$];
    logic [31:0]   mpend = '0;
    logic          m_we  = 1'b0;
    logic [4:0]    m_wa  = '0;
    logic [31:0]   m_wd  = '0;
    bit            cmp_en = 1'b0;
    bit            cap_en = 1'b0;
    logic [31:0]   cap_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Compare against the model, then advance the model with the inputs that the next edge will sample.
    always @(negedge clk) begin
        ent_t e;
        bit   push;
        if (cmp_en) begin
            chk("m_rf_we", ifc.rf_we, m_we);
            if (m_we) begin
                chk("m_rf_wa", ifc.rf_wa, m_wa);
                chk("m_rf_wd", ifc.rf_wd, m_wd);
            end
            chk("m_fifo_cnt", ifc.fifo_cnt, mq.size());
            chk("m_lsu_ready", ifc.lsu_ready, (mq.size() != DEPTH) && !rst);
            chk("m_pend_k", ifc.pend_k, mpend[ifc.pend_ra_k]);
            chk("m_pend_j", ifc.pend_j, mpend[ifc.pend_ra_j]);
            chk("m_pend_d", ifc.pend_d, mpend[ifc.pend_ra_d]);
        end
        if (cap_en && ifc.rf_we && ifc.rf_wd[31:8] == 24'h1)
            cap_q.push_back(ifc.rf_wd);

        if (rst) begin
            mq.delete();
            mpend = '0;
            m_we = 1'b0; m_wa = '0; m_wd = '0;
        end else begin
            push = ifc.lsu_valid && (mq.size() != DEPTH);
            if (ifc.alu_valid) begin
                m_we = (ifc.alu_wa != 0); m_wa = ifc.alu_wa; m_wd = ifc.alu_wd;
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                m_we = (e.wa != 0); m_wa = e.wa; m_wd = e.wd;
                mpend[e.wa] = 1'b0;
            end else if (BYP && push) begin
                m_we = (ifc.lsu_wa != 0); m_wa = ifc.lsu_wa; m_wd = ifc.lsu_wd;
                mpend[ifc.lsu_wa] = 1'b0;
                push = 1'b0;
            end else begin
                m_we = 1'b0;
            end
            if (push) begin
                e.wa = ifc.lsu_wa; e.wd = ifc.lsu_wd;
                mq.push_back(e);
            end
            if (ifc.issue_en && ifc.issue_wa != 0)
                mpend[ifc.issue_wa] = 1'b1;
            mpend[0] = 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int guard;
        bit go;
        ifc.alu_valid = 0; ifc.alu_wa = 0; ifc.alu_wd = 0;
        ifc.lsu_valid = 1; ifc.lsu_wa = 0; ifc.lsu_wd = 0;
        ifc.issue_en = 0; ifc.issue_wa = 0;
        ifc.pend_ra_k = 9; ifc.pend_ra_j = 0; ifc.pend_ra_d = 12;

        // Reset with lsu_valid held high
        step(); step();
        cmp_en = 1'b1;
        chk("rst_lsu_ready", ifc.lsu_ready, 0);
        chk("rst_rf_we", ifc.rf_we, 0);
        chk("rst_rf_wa", ifc.rf_wa, 0);
        chk("rst_rf_wd", ifc.rf_wd, 0);
        chk("rst_fifo_cnt", ifc.fifo_cnt, 0);
        chk("rst_pend", {ifc.pend_k, ifc.pend_j, ifc.pend_d}, 0);
        rst = 1'b0; ifc.lsu_valid = 0;
        #1 chk("post_rst_lsu_ready", ifc.lsu_ready, 1);

        // ALU write and r0 suppression
        ifc.alu_valid = 1; ifc.alu_wa = 5; ifc.alu_wd = 32'h12345678;
        step();
        chk("alu_we", ifc.rf_we, 1);
        chk("alu_wa", ifc.rf_wa, 5);
        chk("alu_wd", ifc.rf_wd, 32'h12345678);
        ifc.alu_wa = 0;
        step();
        ifc.alu_valid = 0;
        chk("alu_r0_we", ifc.rf_we, 0);

        // ALU priority over a buffered LSU entry
        ifc.alu_valid = 1; ifc.alu_wa = 3; ifc.alu_wd = 32'h33;
        ifc.lsu_valid = 1; ifc.lsu_wa = 7; ifc.lsu_wd = 32'hAA;
        step();
        ifc.lsu_valid = 0;
        chk("prio_cnt1", ifc.fifo_cnt, 1);
        chk("prio_wa1", ifc.rf_wa, 3);
        step();
        chk("prio_cnt2", ifc.fifo_cnt, 1);
        step();
        chk("prio_cnt3", ifc.fifo_cnt, 1);
        chk("prio_wa3", ifc.rf_wa, 3);
        ifc.alu_valid = 0;
        step();
        chk("prio_pop_we", ifc.rf_we, 1);
        chk("prio_pop_wa", ifc.rf_wa, 7);
        chk("prio_pop_wd", ifc.rf_wd, 32'hAA);
        chk("prio_pop_cnt", ifc.fifo_cnt, 0);

        // Fill to full under ALU pressure, then drain with wrap
        cap_en = 1'b1;
        ifc.alu_valid = 1;
        for (int i = 0; i < 4; i++) begin
            ifc.lsu_valid = 1; ifc.lsu_wa = 5'(10 + i); ifc.lsu_wd = 32'h100 + 32'(i);
            step();
        end
        ifc.lsu_valid = 0;
        chk("full_cnt", ifc.fifo_cnt, 4);
        chk("full_ready", ifc.lsu_ready, 0);
        ifc.alu_valid = 0;
        n = 4; guard = 0;
        while (n < 10 && guard < 100) begin
            ifc.lsu_valid = 1; ifc.lsu_wa = 5'(10 + n); ifc.lsu_wd = 32'h100 + 32'(n);
            go = ifc.lsu_ready;
            step();
            if (go) n++;
            guard++;
        end
        ifc.lsu_valid = 0;
        chk("wrap_pushed", n, 10);
        guard = 0;
        while (ifc.fifo_cnt != 0 && guard < 100) begin
            step();
            guard++;
        end
        chk("wrap_drain_timeout", guard < 100, 1);
        step();
        cap_en = 1'b0;
        chk("wrap_count", cap_q.size(), 10);
        for (int i = 0; i < 10; i++)
            if (i < cap_q.size())
                chk("wrap_order", cap_q[i], 32'h100 + 32'(i));

        // Scoreboard set, set-beats-clear, and clear on pop
        ifc.issue_en = 1; ifc.issue_wa = 9;
        step();
        chk("sb_set", ifc.pend_k, 1);
        ifc.issue_en = 0;
        ifc.alu_valid = 1; ifc.lsu_valid = 1; ifc.lsu_wa = 9; ifc.lsu_wd = 32'h99;
        step();
        chk("sb_buf_cnt", ifc.fifo_cnt, 1);
        ifc.alu_valid = 0; ifc.lsu_valid = 0; ifc.issue_en = 1; ifc.issue_wa = 9;
        step();
        chk("sb_pop1_we", ifc.rf_we, 1);
        chk("sb_pop1_wa", ifc.rf_wa, 9);
        chk("sb_setwins", ifc.pend_k, 1);
        ifc.issue_en = 0;
        ifc.alu_valid = 1; ifc.lsu_valid = 1; ifc.lsu_wa = 9; ifc.lsu_wd = 32'h9A;
        step();
        chk("sb_still", ifc.pend_k, 1);
        ifc.alu_valid = 0; ifc.lsu_valid = 0;
        step();
        chk("sb_pop2_we", ifc.rf_we, 1);
        chk("sb_pop2_wd", ifc.rf_wd, 32'h9A);
        chk("sb_clear", ifc.pend_k, 0);
        ifc.issue_en = 1; ifc.issue_wa = 0;
        step();
        ifc.issue_en = 0;
        chk("sb_r0", ifc.pend_j, 0);

        // r0 entry from the FIFO pops without writing
        ifc.alu_valid = 1; ifc.lsu_valid = 1; ifc.lsu_wa = 0; ifc.lsu_wd = 32'h55;
        step();
        ifc.alu_valid = 0; ifc.lsu_valid = 0;
        step();
        chk("r0_pop_we", ifc.rf_we, 0);
        chk("r0_pop_cnt", ifc.fifo_cnt, 0);

        // LSU latency with empty FIFO and idle ALU
        ifc.lsu_valid = 1; ifc.lsu_wa = 4; ifc.lsu_wd = 32'h44;
        step();
        ifc.lsu_valid = 0;
        if (BYP) begin
            chk("byp_we", ifc.rf_we, 1);
            chk("byp_wa", ifc.rf_wa, 4);
            chk("byp_cnt", ifc.fifo_cnt, 0);
        end else begin
            chk("nobyp_we_n1", ifc.rf_we, 0);
            chk("nobyp_cnt", ifc.fifo_cnt, 1);
            step();
            chk("nobyp_we_n2", ifc.rf_we, 1);
            chk("nobyp_wa", ifc.rf_wa, 4);
        end
        step();

        // Reset mid-operation discards entries and pending bits
        ifc.alu_valid = 1; ifc.alu_wa = 3;
        ifc.issue_en = 1; ifc.issue_wa = 12;
        ifc.lsu_valid = 1; ifc.lsu_wa = 12; ifc.lsu_wd = 32'hC;
        step(); step();
        ifc.issue_en = 0; ifc.lsu_valid = 0;
        chk("mid_cnt", ifc.fifo_cnt, 2);
        chk("mid_pend", ifc.pend_d, 1);
        rst = 1'b1;
        step();
        rst = 1'b0; ifc.alu_valid = 0;
        chk("mid_rst_cnt", ifc.fifo_cnt, 0);
        chk("mid_rst_pend", ifc.pend_d, 0);
        chk("mid_rst_we", ifc.rf_we, 0);
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-side front end for the 32×32 register file. Merges single-cycle ALU results and buffered long-latency (load) results onto the register file's single write port (`rf_we`/`rf_wa`/`rf_wd`). Keeps a per-register pending scoreboard so decode can stall reads of registers with outstanding long-latency writes. Sits between the execute/memory stages and the register file.

## Interface

**Parameters**
- `DEPTH`, default 4: long-latency result FIFO entries; power of 2, ≥2.

**Ports**
- `clk`, in, 1: clock; all state updates on rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `alu_valid`, in, 1: ALU result present this cycle; no backpressure.
- `alu_wa`, in, 5: ALU destination register.
- `alu_wd`, in, 32: ALU result.
- `lsu_valid`, in, 1: long-latency result offered.
- `lsu_ready`, out, 1: FIFO can accept; transfer occurs when `lsu_valid & lsu_ready`.
- `lsu_wa`, in, 5: long-latency destination register.
- `lsu_wd`, in, 32: long-latency result.
- `issue_en`, in, 1: decode issued a long-latency op this cycle.
- `issue_wa`, in, 5: its destination register.
- `pend_ra_k`, `pend_ra_j`, `pend_ra_d`, in, 5 each: scoreboard query addresses.
- `pend_k`, `pend_j`, `pend_d`, out, 1 each: queried register has an outstanding long-latency write.
- `rf_we`, out, 1: register file write enable.
- `rf_wa`, out, 5: register file write address.
- `rf_wd`, out, 32: register file write data.
- `fifo_cnt`, out, log2(DEPTH)+1: current FIFO occupancy.

## Operation

- **Outputs:** `rf_we`, `rf_wa`, `rf_wd` are registered.
- **Arbitration per cycle:**
  - `alu_valid` wins and loads `alu_wa`/`alu_wd` into the output register.
  - Otherwise, if the FIFO is non-empty, the head entry pops into the output register.
  - Otherwise `rf_we` is 0 next cycle. `rf_wa` and `rf_wd` hold their previous values.
- **r0 handling:** any selected write with address 0 yields `rf_we=0` next cycle. A FIFO entry targeting r0 still pops.
- **FIFO:**
  - Circular buffer with `DEPTH` entries, read/write pointers wrapping modulo `DEPTH`.
  - `lsu_ready = (fifo_cnt != DEPTH) & ~rst`. It does not account for a same-cycle pop.
  - Simultaneous push and pop leaves `fifo_cnt` unchanged.
  - Pop from empty and push when full cannot occur, by construction.
- **Scoreboard:** 32-bit `pending` vector.
  - **Set:** `issue_en` with `issue_wa != 0` sets bit `issue_wa`.
  - **Clear:** a FIFO pop clears bit `head.wa`.
  - **Same cycle, same register:** set wins.
  - ALU writes never touch `pending`.
  - Bit 0 is always 0.
- **Queries:** `pend_x = pending[pend_ra_x]`, combinational from registered state. No bypass of same-cycle set or clear.
- **Starvation:** a continuous `alu_valid` stream starves the FIFO. Upstream guarantees gaps; the block provides no guard.

## Timing

- **Reset values:** `rf_we=0`, `rf_wa=0`, `rf_wd=0`, `fifo_cnt=0`, `pending=0`, FIFO pointers 0, `lsu_ready=0` while `rst=1`.
- **Reset mid-operation:** buffered entries are discarded and pending bits cleared.
- **ALU latency:** `alu_valid` in cycle N gives `rf_we=1` in cycle N+1.
- **LSU latency, no bypass:** accepted in N, popped no earlier than N+1, `rf_we` no earlier than N+2.
- **Scoreboard clear:** `pend_x` drops in the cycle after the pop, which is the same cycle `rf_we` is high for that entry.
- **Back-to-back writes:** one RF write per cycle maximum. Throughput is 1/cycle with any mix of sources.

## Configuration

- **`RF_WB_BYPASS_EN` defined:** in a cycle with the FIFO empty, `alu_valid=0` and an LSU handshake, the LSU result goes directly to the output register without being stored.
  - `fifo_cnt` is unchanged.
  - Pending bit `lsu_wa` clears with the same rules as a pop.
  - LSU latency becomes 1 cycle.
- **Undefined:** every LSU result passes through the FIFO, with a minimum latency of 2 cycles.

## Test plan

- **Reset:** assert `rst` for 2 cycles with `lsu_valid=1` → `lsu_ready=0`, `rf_we=0`, `fifo_cnt=0`, all `pend_*=0`. Deassert → `lsu_ready=1`.
- **ALU write:** `alu_valid=1`, `alu_wa=5`, `alu_wd=0x12345678` in N → N+1: `rf_we=1`, `rf_wa=5`, `rf_wd=0x12345678`. Same stimulus with `alu_wa=0` → `rf_we=0`.
- **Priority:** push LSU `wa=7`, `wd=0xAA` while `alu_valid` is held 3 cycles (`wa=3`) → three ALU writes, then `rf_wa=7`, `rf_wd=0xAA`. `fifo_cnt` is 1 until the pop.
- **Full/wrap:** with `DEPTH=4`, hold `alu_valid=1` and push 4 LSU results → `lsu_ready=0`, `fifo_cnt=4`. Release ALU and push 6 more overall → all 10 drain in order (pointer wrap), `fifo_cnt` returns to 0.
- **Scoreboard:** `issue_en`, `issue_wa=9` → `pend_k=1` for `pend_ra_k=9`. Later pop of `wa=9` coinciding with `issue_en`, `issue_wa=9` → `pend_k` stays 1. A later pop without re-issue → `pend_k=0` in the same cycle `rf_we=1`.
- **Bypass:** with `RF_WB_BYPASS_EN`, FIFO empty and no ALU, LSU `wa=4` in N → `rf_we=1` in N+1 and `fifo_cnt` stays 0. Without the macro → `rf_we` in N+2.
